// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard
// Hazard detection, forwarding-select and flush control for the in-order
// pipeline. Every in-flight register write behind ID is kept in an
// NSTAGE-deep shift register (stage 1 = EX ... stage NSTAGE = WB). Each ID
// source is matched against it to decide:
//   - whether ID must stall;
//   - which stage EX forwards from on the next cycle.

module pipe_hazard_scoreboard #(
  parameter int NSTAGE  = 3,  // stages after ID that can hold a pending write
  parameter int AW      = 5,  // register address width
  parameter int LW      = 2,  // width of the per-instruction latency field
  parameter int FLUSH_D = 1,  // stages behind ID squashed by a flush
  parameter int SW      = 2   // forwarding select width, 2**SW > NSTAGE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_id_valid,
  input  logic [AW-1:0] i_id_rs,
  input  logic [AW-1:0] i_id_rt,
  input  logic          i_id_use_rs,
  input  logic          i_id_use_rt,
  input  logic          i_id_wr_en,
  input  logic [AW-1:0] i_id_rd,
  input  logic [LW-1:0] i_id_lat,
  input  logic          i_flush,
  input  logic          i_hold,
  output logic          o_id_stall,
  output logic [SW-1:0] o_ex_fwd_rs,
  output logic [SW-1:0] o_ex_fwd_rt,
  output logic [31:0]   o_stall_cnt
);

  // Tracker state: one pending-write slot per stage behind ID.
  logic [NSTAGE:1] r_v;
  logic [AW-1:0]   r_rd  [1:NSTAGE];
  logic [LW-1:0]   r_lat [1:NSTAGE];

  // Forwarding selects for the instruction currently in EX, and the stall
  // cycle counter.
  logic [SW-1:0]   r_fwd_rs;
  logic [SW-1:0]   r_fwd_rt;
  logic [31:0]     r_stall_cnt;

  // Per-stage match and "result not yet forwardable" flags.
  logic [NSTAGE:1] w_hit_rs;
  logic [NSTAGE:1] w_hit_rt;
  logic [NSTAGE:1] w_late;

  // Resolved youngest-producer information per source.
  logic            w_rs_live;
  logic            w_rt_live;
  logic            w_haz_rs;
  logic            w_haz_rt;
  logic [SW-1:0]   w_fwd_rs;
  logic [SW-1:0]   w_fwd_rt;

  // Issue control and the next valid vector.
  logic            w_stall;
  logic            w_issue;
  logic [NSTAGE:1] w_v_next;

  // Register 0 is hard-wired, so a source of r0 never creates a dependency.
  assign w_rs_live = i_id_use_rs && (i_id_rs != '0);
  assign w_rt_live = i_id_use_rt && (i_id_rt != '0);

  genvar gi;
  generate
    for (gi = 1; gi <= NSTAGE; gi++) begin : g_stage_cmp
      assign w_hit_rs[gi] = r_v[gi] && (r_rd[gi] == i_id_rs);
      assign w_hit_rt[gi] = r_v[gi] && (r_rd[gi] == i_id_rt);
      // A result becomes forwardable once the producer reaches stage lat.
      // lat=0 behaves as lat=1, and k<1 never holds for k>=1.
      // lat>NSTAGE keeps the consumer waiting until the producer retires.
      assign w_late[gi]   = (r_lat[gi] != '0) && (32'(gi) < 32'(r_lat[gi]));
    end
  endgenerate

  // Youngest producer wins. Scanning from the oldest stage towards stage 1
  // lets the last hit (the smallest k) overwrite older ones.
  always_comb begin
    w_haz_rs = 1'b0;
    w_haz_rt = 1'b0;
    w_fwd_rs = '0;
    w_fwd_rt = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (w_rs_live && w_hit_rs[k]) begin
        w_haz_rs = w_late[k];
        w_fwd_rs = (k < NSTAGE) ? SW'(k + 1) : '0;
      end
      if (w_rt_live && w_hit_rt[k]) begin
        w_haz_rt = w_late[k];
        w_fwd_rt = (k < NSTAGE) ? SW'(k + 1) : '0;
      end
    end
  end

  // A flush suppresses the stall: the instruction in ID is discarded anyway.
  assign w_stall    = i_id_valid && !i_flush && (w_haz_rs || w_haz_rt);
  assign w_issue    = i_id_valid && !w_stall && !i_flush;
  assign o_id_stall = w_stall;

  // Stage 1 gets the issuing write, or a bubble on stall/flush/idle.
  // Writes to r0 are dropped here.
  assign w_v_next[1] = w_issue && i_id_wr_en && (i_id_rd != '0);

  generate
    for (gi = 2; gi <= NSTAGE; gi++) begin : g_v_shift
      if (gi <= FLUSH_D + 1) begin : g_killable
        // Youngest FLUSH_D stages behind ID are wrong-path on a flush.
        assign w_v_next[gi] = r_v[gi-1] && !i_flush;
      end else begin : g_keep
        assign w_v_next[gi] = r_v[gi-1];
      end
    end
  endgenerate

  // Valid bits advance one stage per cycle unless memory holds the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else if (!i_hold) begin
      r_v <= w_v_next;
    end
  end

  // Destination/latency payload follows the valid bits. Stage 1 loads
  // unconditionally because its valid bit alone says whether it matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        r_rd[k]  <= '0;
        r_lat[k] <= '0;
      end
    end else if (!i_hold) begin
      r_rd[1]  <= i_id_rd;
      r_lat[1] <= i_id_lat;
      for (int k = 2; k <= NSTAGE; k++) begin
        r_rd[k]  <= r_rd[k-1];
        r_lat[k] <= r_lat[k-1];
      end
    end
  end

  // Forwarding selects are captured with the issuing instruction. A stall or
  // flush puts a bubble in EX, so the selects clear. With ID idle they keep
  // the value of the last issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_rs <= '0;
      r_fwd_rt <= '0;
    end else if (!i_hold) begin
      if (w_issue) begin
        r_fwd_rs <= w_fwd_rs;
        r_fwd_rt <= w_fwd_rt;
      end else if (w_stall || i_flush) begin
        r_fwd_rs <= '0;
        r_fwd_rt <= '0;
      end
    end
  end

  // Count stall cycles that actually cost a cycle. Held cycles are excluded.
  // The count saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!i_hold && w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_ex_fwd_rs = r_fwd_rs;
  assign o_ex_fwd_rt = r_fwd_rt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard (NSTAGE=3, FLUSH_D=1).
// A behavioural tracker model predicts id_stall each cycle. It also queues the
// expected registered outputs, which are compared after the clock edge.
// Directed scenarios add fixed expected values on top.

module tb_pipe_hazard_scoreboard;

  localparam int NSTAGE = 3;
  localparam int AW     = 5;
  localparam int LW     = 2;
  localparam int SW     = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_id_valid;
  logic [AW-1:0] i_id_rs;
  logic [AW-1:0] i_id_rt;
  logic          i_id_use_rs;
  logic          i_id_use_rt;
  logic          i_id_wr_en;
  logic [AW-1:0] i_id_rd;
  logic [LW-1:0] i_id_lat;
  logic          i_flush;
  logic          i_hold;
  logic          o_id_stall;
  logic [SW-1:0] o_ex_fwd_rs;
  logic [SW-1:0] o_ex_fwd_rt;
  logic [31:0]   o_stall_cnt;

  pipe_hazard_scoreboard #(
    .NSTAGE(NSTAGE), .AW(AW), .LW(LW), .FLUSH_D(1), .SW(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(i_id_valid), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_use_rs(i_id_use_rs), .i_id_use_rt(i_id_use_rt),
    .i_id_wr_en(i_id_wr_en), .i_id_rd(i_id_rd), .i_id_lat(i_id_lat),
    .i_flush(i_flush), .i_hold(i_hold),
    .o_id_stall(o_id_stall), .o_ex_fwd_rs(o_ex_fwd_rs),
    .o_ex_fwd_rt(o_ex_fwd_rt), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] fwd_rs;
    logic [SW-1:0] fwd_rt;
    logic [31:0]   cnt;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference tracker.
  bit          m_v   [1:NSTAGE];
  logic [4:0]  m_rd  [1:NSTAGE];
  logic [1:0]  m_lat [1:NSTAGE];
  logic [1:0]  m_fwd_rs;
  logic [1:0]  m_fwd_rt;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 1; k <= NSTAGE; k++) begin
      m_v[k] = 1'b0; m_rd[k] = '0; m_lat[k] = '0;
    end
    m_fwd_rs = '0; m_fwd_rt = '0; m_cnt = '0;
  endtask

  // Stage index of the youngest producer of s, 0 if none.
  function automatic int m_find(input logic [4:0] s, input bit used);
    if (!used || s == 5'd0) return 0;
    for (int k = 1; k <= NSTAGE; k++)
      if (m_v[k] && m_rd[k] == s) return k;
    return 0;
  endfunction

  function automatic bit m_waits(input int k);
    int eff;
    if (k == 0) return 1'b0;
    eff = (m_lat[k] == 2'd0) ? 1 : int'(m_lat[k]);
    return k < eff;
  endfunction

  function automatic logic [1:0] m_sel(input int k);
    return (k != 0 && k < NSTAGE) ? 2'(k + 1) : 2'd0;
  endfunction

  // One ID cycle: drive at negedge, check stall, queue registered
  // expectations, then compare them after the rising edge.
  task automatic step(input bit v, input logic [4:0] rs, input bit urs,
                      input logic [4:0] rt, input bit urt, input bit wr,
                      input logic [4:0] rd, input logic [1:0] lat,
                      input bit fl, input bit hd, output bit st);
    int   ka, kb;
    bit   e_st, e_iss;
    exp_t e, g;
    @(negedge clk);
    i_id_valid = v;  i_id_rs = rs; i_id_use_rs = urs;
    i_id_rt = rt;    i_id_use_rt = urt;
    i_id_wr_en = wr; i_id_rd = rd; i_id_lat = lat;
    i_flush = fl;    i_hold = hd;
    #1;
    ka    = m_find(rs, urs);
    kb    = m_find(rt, urt);
    e_st  = v && !fl && (m_waits(ka) || m_waits(kb));
    e_iss = v && !e_st && !fl;
    check("id_stall", o_id_stall, e_st);
    st = o_id_stall;
    if (!hd) begin
      for (int k = NSTAGE; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_lat[k] = m_lat[k-1];
      end
      m_v[1] = e_iss && wr && (rd != 5'd0);
      m_rd[1] = rd; m_lat[1] = lat;
      if (fl) m_v[2] = 1'b0;
      if (e_iss) begin
        m_fwd_rs = m_sel(ka); m_fwd_rt = m_sel(kb);
      end else if (e_st || fl) begin
        m_fwd_rs = '0; m_fwd_rt = '0;
      end
      if (e_st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    e.fwd_rs = m_fwd_rs; e.fwd_rt = m_fwd_rt; e.cnt = m_cnt;
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    if (q_exp.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      g = q_exp.pop_front();
      check("ex_fwd_rs", o_ex_fwd_rs, g.fwd_rs);
      check("ex_fwd_rt", o_ex_fwd_rt, g.fwd_rt);
      check("stall_cnt", o_stall_cnt, g.cnt);
    end
    $display("txn v=%0b rs=%0d rt=%0d rd=%0d lat=%0d fl=%0b hd=%0b -> stall=%0b fwd=%0d/%0d cnt=%0d",
             v, rs, rt, rd, lat, fl, hd, st, o_ex_fwd_rs, o_ex_fwd_rt, o_stall_cnt);
  endtask

  task automatic drain();
    bit st;
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
  endtask

  // Bound the whole run.
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    rst_n = 1'b0;
    i_id_valid = 0; i_id_rs = 0; i_id_rt = 0; i_id_use_rs = 0; i_id_use_rt = 0;
    i_id_wr_en = 0; i_id_rd = 0; i_id_lat = 0; i_flush = 0; i_hold = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_stall", o_id_stall, 0);
    check("rst_fwd_rs", o_ex_fwd_rs, 0);
    check("rst_fwd_rt", o_ex_fwd_rt, 0);
    check("rst_cnt", o_stall_cnt, 0);

    // ALU RAW: add r8, then add r9,r8,r8 forwards from stage 2 with no stall.
    step(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, st);
    step(1, 8, 1, 8, 1, 1, 9, 1, 0, 0, st);
    check("alu_stall", st, 0);
    check("alu_fwd_rs", o_ex_fwd_rs, 2);
    check("alu_fwd_rt", o_ex_fwd_rt, 2);
    drain();

    // Load-use: one stall cycle, then forwarding from stage 3, later from the RF.
    step(1, 0, 0, 0, 0, 1, 8, 2, 0, 0, st);
    step(1, 8, 1, 0, 0, 1, 10, 1, 0, 0, st);
    check("lu_stall", st, 1);
    check("lu_cnt", o_stall_cnt, 1);
    check("lu_bubble_fwd", o_ex_fwd_rs, 0);
    step(1, 8, 1, 0, 0, 1, 10, 1, 0, 0, st);
    check("lu_issue_stall", st, 0);
    check("lu_fwd_rs", o_ex_fwd_rs, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    step(1, 8, 1, 0, 0, 1, 10, 1, 0, 0, st);
    check("lu_late_stall", st, 0);
    check("lu_late_fwd", o_ex_fwd_rs, 0);
    drain();

    // WAW: the younger load of r8 is the producer that counts. A write to r0 never matches.
    step(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, st);
    step(1, 0, 0, 0, 0, 1, 8, 2, 0, 0, st);
    step(1, 8, 1, 0, 0, 1, 11, 1, 0, 0, st);
    check("waw_stall", st, 1);
    check("waw_cnt", o_stall_cnt, 2);
    step(1, 8, 1, 0, 0, 1, 11, 1, 0, 0, st);
    check("waw_fwd_rs", o_ex_fwd_rs, 3);
    step(1, 0, 0, 0, 0, 1, 0, 2, 0, 0, st);
    step(1, 0, 1, 0, 1, 1, 12, 1, 0, 0, st);
    check("r0_stall", st, 0);
    check("r0_fwd_rs", o_ex_fwd_rs, 0);
    check("r0_fwd_rt", o_ex_fwd_rt, 0);
    drain();

    // Flush with all stages full: stages 1-2 are squashed and ID does not issue.
    step(1, 0, 0, 0, 0, 1, 1, 3, 0, 0, st);
    step(1, 0, 0, 0, 0, 1, 2, 3, 0, 0, st);
    step(1, 0, 0, 0, 0, 1, 3, 3, 0, 0, st);
    step(1, 3, 1, 0, 0, 1, 5, 1, 1, 0, st);
    check("fl_stall", st, 0);
    check("fl_cnt", o_stall_cnt, 2);
    step(1, 3, 1, 5, 1, 1, 6, 1, 0, 0, st);
    check("fl_after_stall", st, 0);
    check("fl_after_fwd_rs", o_ex_fwd_rs, 0);
    check("fl_after_fwd_rt", o_ex_fwd_rt, 0);
    drain();

    // Hold during a load-use stall: everything stays frozen, then resumes.
    step(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, st);
    step(1, 7, 1, 0, 0, 1, 8, 2, 0, 0, st);
    check("hd_pre_fwd", o_ex_fwd_rs, 2);
    repeat (4) begin
      step(1, 8, 1, 0, 0, 1, 13, 1, 0, 1, st);
      check("hd_stall", st, 1);
      check("hd_cnt", o_stall_cnt, 2);
      check("hd_fwd", o_ex_fwd_rs, 2);
    end
    step(1, 8, 1, 0, 0, 1, 13, 1, 0, 0, st);
    check("hd_rel_stall", st, 1);
    check("hd_rel_cnt", o_stall_cnt, 3);
    step(1, 8, 1, 0, 0, 1, 13, 1, 0, 0, st);
    check("hd_issue_stall", st, 0);
    check("hd_issue_fwd", o_ex_fwd_rs, 3);
    drain();

    // Random traffic on a small register set, checked against the model.
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 3) != 0,
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, st);
    end
    drain();

    // Asynchronous reset mid-cycle with all stages valid and a pending stall.
    step(1, 0, 0, 0, 0, 1, 2, 3, 0, 0, st);
    step(1, 0, 0, 0, 0, 1, 3, 3, 0, 0, st);
    step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, st);
    step(1, 1, 1, 0, 0, 1, 4, 3, 0, 0, st);
    check("ar_pre_fwd", o_ex_fwd_rs, 2);
    @(negedge clk);
    i_id_valid = 1; i_id_rs = 4; i_id_use_rs = 1; i_id_rt = 0; i_id_use_rt = 0;
    i_id_wr_en = 0; i_id_rd = 0; i_id_lat = 1; i_flush = 0; i_hold = 0;
    #1;
    check("ar_pre_stall", o_id_stall, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_stall", o_id_stall, 0);
    check("ar_fwd_rs", o_ex_fwd_rs, 0);
    check("ar_fwd_rt", o_ex_fwd_rt, 0);
    check("ar_cnt", o_stall_cnt, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ar_post_stall", o_id_stall, 0);
    step(1, 4, 1, 0, 0, 1, 9, 2, 0, 0, st);
    step(1, 9, 1, 0, 0, 0, 0, 1, 0, 0, st);
    check("ar_resume_stall", st, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
